trace_lockstep_checker: RTL and testbench
=========================================

// Module: trace_lockstep_checker
// PURPOSE
//  Synthesizable consumer of two picorv32 trace streams (trace_valid/trace_data) from cores run in lockstep.
//  Per-stream FIFOs absorb bounded skew between the cores; retired trace words are compared in order.
//  First divergence or overflow latches a sticky failure.
//  Sits downstream of the two cores' trace ports; usable on FPGA or under formal as a bounded-skew checker.
// PARAMETERS
//  DEPTH  8   entries per stream FIFO; power of two, >=2; max tolerated skew in trace words
//  WIDTH  36  trace word width, matches picorv32 trace_data
// PORTS
//  clk            in   1              clock, all logic on posedge
//  reset          in   1              synchronous, active-high
//  trace_valid_0  in   1              stream 0 word valid this cycle
//  trace_data_0   in   WIDTH          stream 0 word
//  trace_valid_1  in   1              stream 1 word valid this cycle
//  trace_data_1   in   WIDTH          stream 1 word
//  fail           out  1              sticky: mismatch | overflow
//  mismatch       out  1              sticky: compared pair differed
//  overflow       out  1              sticky: word arrived to full FIFO with no pop
//  fail_data_0    out  WIDTH          stream 0 word of the failing pair (0 if overflow-only)
//  fail_data_1    out  WIDTH          stream 1 word of the failing pair
//  match_count    out  32             pairs compared equal, saturating at 32'hFFFF_FFFF
//  level_0        out  $clog2(DEPTH)+1  FIFO 0 occupancy
//  level_1        out  $clog2(DEPTH)+1  FIFO 1 occupancy
// BEHAVIOUR
//  - Reset: all outputs 0, both FIFOs empty, state RUN. Reset mid-operation discards FIFO contents.
//  - States: RUN -> FAIL on first mismatch or overflow; FAIL is terminal until reset.
//  - RUN push: trace_valid_k writes trace_data_k into FIFO k at the edge.
//    Push is accepted if not full, or if full and a pop of FIFO k occurs in the same cycle.
//  - RUN pop/compare: when both FIFOs are non-empty at cycle start, both heads pop at the edge.
//    Equal heads: match_count increments. Unequal: mismatch<=1, fail_data_k<=head_k, state<=FAIL.
//  - Latency: words pushed at edge t are compared at edge t+1. Mismatch is visible after edge t+1.
//    Throughput is one pair per cycle; no bypass path.
//  - Overflow: valid_k while FIFO k is full and not popping -> overflow<=1, word dropped, state<=FAIL.
//  - Simultaneous overflow and mismatch in one cycle: both flags set; fail_data holds the compared pair.
//  - FAIL: no pushes, pops, or counter changes; all outputs frozen.
//  - Pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. Full = MSB differs, rest equal.
//  - level_k = wr_ptr_k - rd_ptr_k, registered with the pointers.
//  - fail = mismatch | overflow, combinational from the registered flags.
// CONFIGURATION
//  TRACE_CMP_MASK_EN defined:
//    - adds input port cmp_mask [WIDTH-1:0];
//    - pair is equal iff ((head_0 ^ head_1) & cmp_mask) == 0;
//    - cmp_mask is sampled in the compare cycle.
//  TRACE_CMP_MASK_EN undefined: port absent; full WIDTH-bit equality compare.
// TESTING
//  1. Both valid same cycle with 36'h0_1234_5678, 3 cycles -> match_count=3, fail=0, levels return to 0.
//  2. Stream 0 leads by 5 words, stream 1 replays same words -> level_0 peaks at 5, match_count=5, fail=0.
//  3. 3rd pair differs (36'h1_0000_0010 vs 36'h1_0000_0014) -> mismatch=1 one edge after pop;
//     fail_data_0/1 hold those values; match_count=2 and frozen.
//  4. Stream 0 pushes DEPTH+1 words, stream 1 idle -> overflow=1 on word 9 (DEPTH=8), level_0=8, mismatch=0.
//  5. FIFO 0 full, both valid with non-empty FIFO 1 -> pop+push same cycle, no overflow, level_0 stays 8.
//  6. Reset asserted in FAIL with non-empty FIFOs -> all outputs 0 next cycle; compare resumes normally.
//     With TRACE_CMP_MASK_EN, mask=36'h0_FFFF_FFFF, pair differs only in bits 35:32 -> no mismatch.

Source files
------------

// File: rtl/trace_lockstep_checker.sv
// trace_lockstep_checker: compares two lockstep picorv32 trace streams.
// Each stream is buffered in its own FIFO to absorb skew between the cores.
// Retired words are compared in order. The first divergence or overflow
// latches a sticky failure.
// Optional feature macro: TRACE_CMP_MASK_EN adds a cmp_mask input.
// Only bits set in cmp_mask take part in the compare.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | accepting pushes, popping and comparing head pairs
// ST_FAIL  | mismatch or overflow seen; everything frozen until reset
module trace_lockstep_checker #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trace_valid_0,
  input  logic [WIDTH-1:0]         trace_data_0,
  input  logic                     trace_valid_1,
  input  logic [WIDTH-1:0]         trace_data_1,
`ifdef TRACE_CMP_MASK_EN
  input  logic [WIDTH-1:0]         cmp_mask,
`endif
  output logic                     fail,
  output logic                     mismatch,
  output logic                     overflow,
  output logic [WIDTH-1:0]         fail_data_0,
  output logic [WIDTH-1:0]         fail_data_1,
  output logic [31:0]              match_count,
  output logic [$clog2(DEPTH):0]   level_0,
  output logic [$clog2(DEPTH):0]   level_1
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_FAIL = 1'b1;

  logic [WIDTH-1:0] mem0_q [DEPTH];
  logic [WIDTH-1:0] mem1_q [DEPTH];

  logic          state_q, state_d;
  logic [PW-1:0] wr0_q, wr0_d, rd0_q, rd0_d;
  logic [PW-1:0] wr1_q, wr1_d, rd1_q, rd1_d;
  logic [PW-1:0] level0_q, level0_d, level1_q, level1_d;
  logic          mismatch_q, mismatch_d, overflow_q, overflow_d;
  logic [WIDTH-1:0] fd0_q, fd0_d, fd1_q, fd1_d;
  logic [31:0]   count_q, count_d;

  logic run, empty0, empty1, full0, full1, pop, push0, push1, ovf0, ovf1, pair_eq;
  logic [WIDTH-1:0] head0, head1, diff;

  // Pointer-based status; the extra MSB tells full from empty.
  assign run    = (state_q == ST_RUN);
  assign empty0 = (wr0_q == rd0_q);
  assign empty1 = (wr1_q == rd1_q);
  assign full0  = (wr0_q[AW] != rd0_q[AW]) && (wr0_q[AW-1:0] == rd0_q[AW-1:0]);
  assign full1  = (wr1_q[AW] != rd1_q[AW]) && (wr1_q[AW-1:0] == rd1_q[AW-1:0]);

  // A full FIFO still takes a word when its head leaves in the same cycle.
  assign pop   = run && !empty0 && !empty1;
  assign push0 = run && trace_valid_0 && (!full0 || pop);
  assign push1 = run && trace_valid_1 && (!full1 || pop);
  assign ovf0  = run && trace_valid_0 && full0 && !pop;
  assign ovf1  = run && trace_valid_1 && full1 && !pop;

  assign head0 = mem0_q[rd0_q[AW-1:0]];
  assign head1 = mem1_q[rd1_q[AW-1:0]];
`ifdef TRACE_CMP_MASK_EN
  assign diff  = (head0 ^ head1) & cmp_mask;
`else
  assign diff  = head0 ^ head1;
`endif
  assign pair_eq = (diff == '0);

  // Next-state: pop/compare, push, overflow detection and failure latching.
  always_comb begin
    state_d    = state_q;
    wr0_d      = wr0_q;
    rd0_d      = rd0_q;
    wr1_d      = wr1_q;
    rd1_d      = rd1_q;
    mismatch_d = mismatch_q;
    overflow_d = overflow_q;
    fd0_d      = fd0_q;
    fd1_d      = fd1_q;
    count_d    = count_q;
    if (pop) begin
      rd0_d = rd0_q + PW'(1);
      rd1_d = rd1_q + PW'(1);
      if (pair_eq) begin
        if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
      end else begin
        mismatch_d = 1'b1;
        fd0_d      = head0;
        fd1_d      = head1;
      end
    end
    if (push0) wr0_d = wr0_q + PW'(1);
    if (push1) wr1_d = wr1_q + PW'(1);
    if (ovf0 || ovf1) overflow_d = 1'b1;
    if (mismatch_d || overflow_d) state_d = ST_FAIL;
    level0_d = wr0_d - rd0_d;
    level1_d = wr1_d - rd1_d;
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wr0_q      <= '0;
      rd0_q      <= '0;
      wr1_q      <= '0;
      rd1_q      <= '0;
      level0_q   <= '0;
      level1_q   <= '0;
      mismatch_q <= 1'b0;
      overflow_q <= 1'b0;
      fd0_q      <= '0;
      fd1_q      <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr0_q      <= wr0_d;
      rd0_q      <= rd0_d;
      wr1_q      <= wr1_d;
      rd1_q      <= rd1_d;
      level0_q   <= level0_d;
      level1_q   <= level1_d;
      mismatch_q <= mismatch_d;
      overflow_q <= overflow_d;
      fd0_q      <= fd0_d;
      fd1_q      <= fd1_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push0) mem0_q[wr0_q[AW-1:0]] <= trace_data_0;
    if (push1) mem1_q[wr1_q[AW-1:0]] <= trace_data_1;
  end

  assign mismatch    = mismatch_q;
  assign overflow    = overflow_q;
  assign fail        = mismatch_q | overflow_q;
  assign fail_data_0 = fd0_q;
  assign fail_data_1 = fd1_q;
  assign match_count = count_q;
  assign level_0     = level0_q;
  assign level_1     = level1_q;

endmodule

// File: tb/tb_trace_lockstep_checker.sv
// Directed bench for trace_lockstep_checker with a queue-based reference model.
module tb_trace_lockstep_checker;
  localparam int DEPTH = 8;
  localparam int WIDTH = 36;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             trace_valid_0 = 1'b0, trace_valid_1 = 1'b0;
  logic [WIDTH-1:0] trace_data_0 = '0, trace_data_1 = '0;
  logic [WIDTH-1:0] cmp_mask = '1;
  logic             fail, mismatch, overflow;
  logic [WIDTH-1:0] fail_data_0, fail_data_1;
  logic [31:0]      match_count;
  logic [3:0]       level_0, level_1;

  trace_lockstep_checker #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .trace_valid_0(trace_valid_0), .trace_data_0(trace_data_0),
    .trace_valid_1(trace_valid_1), .trace_data_1(trace_data_1),
`ifdef TRACE_CMP_MASK_EN
    .cmp_mask(cmp_mask),
`endif
    .fail(fail), .mismatch(mismatch), .overflow(overflow),
    .fail_data_0(fail_data_0), .fail_data_1(fail_data_1),
    .match_count(match_count), .level_0(level_0), .level_1(level_1)
  );

  always #5 clk = ~clk;

  // Reference model: expected words queue per stream, popped as pairs compare.
  logic [WIDTH-1:0] m0[$], m1[$];
  logic [31:0]      m_cnt;
  bit               m_mis, m_ovf;
  logic [WIDTH-1:0] m_fd0, m_fd1;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit v0, input logic [WIDTH-1:0] d0,
                            input bit v1, input logic [WIDTH-1:0] d1);
    bit pop, full0, full1;
    logic [WIDTH-1:0] h0, h1;
    if (rst) begin
      m0.delete(); m1.delete();
      m_cnt = 0; m_mis = 0; m_ovf = 0; m_fd0 = 0; m_fd1 = 0;
    end else if (!(m_mis || m_ovf)) begin
      pop   = (m0.size() != 0) && (m1.size() != 0);
      full0 = (m0.size() == DEPTH);
      full1 = (m1.size() == DEPTH);
      if (pop) begin
        h0 = m0.pop_front();
        h1 = m1.pop_front();
        if (((h0 ^ h1) & cmp_mask) == '0) begin
          if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end else begin
          m_mis = 1; m_fd0 = h0; m_fd1 = h1;
        end
      end
      if (v0) begin if (!full0 || pop) m0.push_back(d0); else m_ovf = 1; end
      if (v1) begin if (!full1 || pop) m1.push_back(d1); else m_ovf = 1; end
    end
  endtask

  task automatic check_all();
    chk("level_0", 64'(level_0), 64'(m0.size()));
    chk("level_1", 64'(level_1), 64'(m1.size()));
    chk("match_count", 64'(match_count), 64'(m_cnt));
    chk("mismatch", 64'(mismatch), 64'(m_mis));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("fail", 64'(fail), 64'(m_mis | m_ovf));
    chk("fail_data_0", 64'(fail_data_0), 64'(m_fd0));
    chk("fail_data_1", 64'(fail_data_1), 64'(m_fd1));
  endtask

  task automatic step(input bit rst, input bit v0, input logic [WIDTH-1:0] d0,
                      input bit v1, input logic [WIDTH-1:0] d1);
    @(negedge clk);
    reset = rst; trace_valid_0 = v0; trace_data_0 = d0;
    trace_valid_1 = v1; trace_data_1 = d1;
    @(posedge clk);
    model_edge(rst, v0, d0, v1, d1);
    #1 check_all();
  endtask

  logic [WIDTH-1:0] w [8];
  logic [WIDTH-1:0] n0, n1;

  initial begin
    // Reset state
    step(1, 0, '0, 0, '0);
    chk("reset_fail", 64'(fail), 64'd0);

    // 1: three equal pairs in lockstep
    for (int i = 0; i < 3; i++) step(0, 1, 36'h0_1234_5678, 1, 36'h0_1234_5678);
    step(0, 0, '0, 0, '0);
    chk("t1_count", 64'(match_count), 64'd3);
    chk("t1_level0", 64'(level_0), 64'd0);

    // 2: stream 0 leads by five words, stream 1 replays them
    for (int i = 0; i < 5; i++) step(0, 1, 36'(36'h2_0000_0000 + i), 0, '0);
    chk("t2_peak", 64'(level_0), 64'd5);
    for (int i = 0; i < 5; i++) step(0, 0, '0, 1, 36'(36'h2_0000_0000 + i));
    step(0, 0, '0, 0, '0);
    chk("t2_count", 64'(match_count), 64'd8);
    chk("t2_fail", 64'(fail), 64'd0);

    // 3: third pair differs, stream 0 ahead so FIFO 0 is non-empty in FAIL
    step(1, 0, '0, 0, '0);
    w[0] = 36'h1_0000_0001; w[1] = 36'h1_0000_0002; w[2] = 36'h1_0000_0010;
    step(0, 1, w[0], 0, '0);
    step(0, 1, w[1], 0, '0);
    step(0, 1, w[2], 0, '0);
    step(0, 1, 36'h1_0000_0020, 1, w[0]);
    step(0, 1, 36'h1_0000_0021, 1, w[1]);
    step(0, 1, 36'h1_0000_0022, 1, 36'h1_0000_0014);
    chk("t3_pre_mismatch", 64'(mismatch), 64'd0);
    step(0, 0, '0, 0, '0);
    chk("t3_mismatch", 64'(mismatch), 64'd1);
    chk("t3_fd0", 64'(fail_data_0), 64'h1_0000_0010);
    chk("t3_fd1", 64'(fail_data_1), 64'h1_0000_0014);
    for (int i = 0; i < 3; i++) step(0, 1, 36'h5, 1, 36'h5);
    chk("t3_frozen_count", 64'(match_count), 64'd2);
    chk("t3_frozen_level0", 64'(level_0), 64'd3);

    // 6: reset in FAIL with non-empty FIFO, then compare resumes
    step(1, 0, '0, 0, '0);
    chk("t6_fail", 64'(fail), 64'd0);
    chk("t6_level0", 64'(level_0), 64'd0);
    step(0, 1, 36'h6_0000_0001, 1, 36'h6_0000_0001);
    step(0, 1, 36'h6_0000_0002, 1, 36'h6_0000_0002);
    step(0, 0, '0, 0, '0);
    chk("t6_count", 64'(match_count), 64'd2);

    // 4: stream 0 pushes DEPTH+1 words, stream 1 idle
    step(1, 0, '0, 0, '0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 36'(36'h4_0000_0000 + i), 0, '0);
    chk("t4_overflow", 64'(overflow), 64'd1);
    chk("t4_level0", 64'(level_0), 64'd8);
    chk("t4_mismatch", 64'(mismatch), 64'd0);

    // 5: FIFO 0 full and FIFO 1 non-empty -> pop and push in the same cycle
    step(1, 0, '0, 0, '0);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 36'(36'h5_0000_0000 + i), 0, '0);
    step(0, 1, 36'(36'h5_0000_0007), 1, 36'h5_0000_0000);
    chk("t5_full", 64'(level_0), 64'd8);
    step(0, 1, 36'h5_0000_0008, 1, 36'h5_0000_0001);
    chk("t5_level0", 64'(level_0), 64'd8);
    chk("t5_overflow", 64'(overflow), 64'd0);
    for (int i = 2; i < 9; i++) step(0, 0, '0, 1, 36'(36'h5_0000_0000 + i));
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, '0);
    chk("t5_count", 64'(match_count), 64'd9);
    chk("t5_fail", 64'(fail), 64'd0);

`ifdef TRACE_CMP_MASK_EN
    // Masked compare: differences only in bits 35:32 are ignored
    step(1, 0, '0, 0, '0);
    cmp_mask = 36'h0_FFFF_FFFF;
    step(0, 1, 36'h3_AAAA_5555, 1, 36'h0_AAAA_5555);
    step(0, 0, '0, 0, '0);
    chk("mask_mismatch", 64'(mismatch), 64'd0);
    chk("mask_count", 64'(match_count), 64'd1);
    cmp_mask = '1;
`endif

    // Random skew between two identical sequences; model decides the outcome
    step(1, 0, '0, 0, '0);
    n0 = 36'h7_0000_0000; n1 = 36'h7_0000_0000;
    for (int i = 0; i < 40; i++) begin
      bit a, b;
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      step(0, a, n0, b, n1);
      if (a) n0 = n0 + 36'd1;
      if (b) n1 = n1 + 36'd1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
